// File: rtl/vote_pkg.sv
// Shared types, width helpers and default timing constants
// for the vote button qualifier.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } chan_state_e;

    // 1 s hold and 0.5 s cooldown at 100 MHz
    localparam int VP_HOLD_DEFAULT = 100_000_000;
    localparam int VP_COOL_DEFAULT = 50_000_000;

    function automatic int vp_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int vp_max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/vote_chan_qual.sv
// One button channel: 2-flop synchroniser, hold counter
// and IDLE/COUNT/HELD FSM producing a single fire pulse.
module vote_chan_qual
    import vote_pkg::*;
#(
    parameter int HOLD_CYCLES = VP_HOLD_DEFAULT,
    parameter int CNT_W       = vp_max1(vp_clog2(HOLD_CYCLES + 1))
) (
    input  logic clock,
    input  logic reset,
    input  logic button_i,
    output logic fire_o
);

    localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(HOLD_CYCLES);

    logic        s1_q;
    logic        s2_q;
    chan_state_e state_q;
    chan_state_e state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the raw button level into the clock domain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= button_i;
            s2_q <= s1_q;
        end
    end

    // FSM state and hold counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: any low sample drops back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_V) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Fire on the sample that completes the hold time
    always_comb begin
        fire_o = (state_q == COUNT) && s2_q && (cnt_q == HOLD_V);
    end

endmodule

// File: rtl/vote_button_array.sv
// Vote button front end: per-channel qualifiers, a single-vote
// arbiter with conflict rejection and a post-vote cooldown.
module vote_button_array
    import vote_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int HOLD_CYCLES     = VP_HOLD_DEFAULT,
    parameter int COOLDOWN_CYCLES = VP_COOL_DEFAULT,
    parameter int CNT_W           = vp_max1(vp_clog2(HOLD_CYCLES + 1)),
    parameter int CH_W            = vp_max1(vp_clog2(NUM_CH))
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] button,
    output logic              vote_valid,
    output logic [CH_W-1:0]   vote_ch,
    output logic              conflict,
    output logic              busy
);

    localparam int COOL_W = vp_max1(vp_clog2(COOLDOWN_CYCLES + 1));
    localparam logic [COOL_W-1:0] COOL_V = COOL_W'(COOLDOWN_CYCLES);

    logic [NUM_CH-1:0] fire;
    logic [CH_W:0]     pop;
    logic [CH_W-1:0]   idx;

    logic              vv_q, vv_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              cf_q, cf_d;
    logic              busy_q, busy_d;
    logic [COOL_W-1:0] cool_q, cool_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        vote_chan_qual #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .CNT_W      (CNT_W)
        ) u_qual (
            .clock   (clock),
            .reset   (reset),
            .button_i(button[g]),
            .fire_o  (fire[g])
        );
    end

    // Count fires and encode the (single) firing channel
    always_comb begin
        pop = '0;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (fire[i]) begin
                pop = pop + (CH_W + 1)'(1);
                idx = CH_W'(i);
            end
        end
    end

    // Arbitrate fires against the cooldown window
    always_comb begin
        vv_d   = 1'b0;
        ch_d   = '0;
        cf_d   = 1'b0;
        cool_d = cool_q;
        if (cool_q != '0) begin
            cool_d = cool_q - COOL_W'(1);
        end
        if ((|fire) && (cool_q == '0)) begin
            if (pop == (CH_W + 1)'(1)) begin
                vv_d = 1'b1;
                ch_d = idx;
            end else begin
                cf_d = 1'b1;
            end
            cool_d = COOL_V;
        end
        busy_d = (cool_d != '0);
    end

    // Registered outputs and cooldown counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vv_q   <= 1'b0;
            ch_q   <= '0;
            cf_q   <= 1'b0;
            busy_q <= 1'b0;
            cool_q <= '0;
        end else begin
            vv_q   <= vv_d;
            ch_q   <= ch_d;
            cf_q   <= cf_d;
            busy_q <= busy_d;
            cool_q <= cool_d;
        end
    end

    assign vote_valid = vv_q;
    assign vote_ch    = ch_q;
    assign conflict   = cf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vote_button_array.sv
// Directed bench for vote_button_array with
// HOLD_CYCLES=5 and COOLDOWN_CYCLES=3.
module tb_vote_button_array;

    logic       clock;
    logic       reset;
    logic [3:0] button;
    logic       vote_valid;
    logic [1:0] vote_ch;
    logic       conflict;
    logic       busy;

    int npass;
    int ntotal;
    int vv_n;
    int cf_n;
    int at;

    vote_button_array #(
        .NUM_CH         (4),
        .HOLD_CYCLES    (5),
        .COOLDOWN_CYCLES(3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .button    (button),
        .vote_valid(vote_valid),
        .vote_ch   (vote_ch),
        .conflict  (conflict),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        vv_n = 0;
        cf_n = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (vote_valid === 1'b1) vv_n++;
            if (conflict === 1'b1) cf_n++;
        end
    endtask

    task automatic wait_vote(input int maxn, output int w);
        w = -1;
        for (int i = 1; i <= maxn; i++) begin
            tick();
            if (vote_valid === 1'b1) begin
                w = i;
                break;
            end
        end
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        reset  = 1'b0;
        button = 4'b0000;
        run(3);
        chk("rst_vv", {31'd0, vote_valid}, 0);
        chk("rst_ch", {30'd0, vote_ch}, 0);
        chk("rst_cf", {31'd0, conflict}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        run(2);

        // single press on channel 2
        button[2] = 1'b1;
        run(7);
        chk("single_early", vv_n, 0);
        tick();
        chk("single_vv", {31'd0, vote_valid}, 1);
        chk("single_ch", {30'd0, vote_ch}, 2);
        chk("single_busy0", {31'd0, busy}, 1);
        chk("single_cf", {31'd0, conflict}, 0);
        tick();
        chk("single_vv_off", {31'd0, vote_valid}, 0);
        chk("single_ch_off", {30'd0, vote_ch}, 0);
        chk("single_busy1", {31'd0, busy}, 1);
        tick();
        chk("single_busy2", {31'd0, busy}, 1);
        tick();
        chk("single_busy3", {31'd0, busy}, 0);
        run(10);
        chk("single_held", vv_n, 0);
        button[2] = 1'b0;
        run(4);

        // glitch restarts qualification on channel 1
        button[1] = 1'b1;
        run(4);
        chk("glitch_pre", vv_n, 0);
        button[1] = 1'b0;
        run(1);
        button[1] = 1'b1;
        wait_vote(20, at);
        chk("glitch_at", at, 8);
        chk("glitch_ch", {30'd0, vote_ch}, 1);
        run(3);
        button[1] = 1'b0;
        run(5);

        // simultaneous qualification on 0 and 3
        button[0] = 1'b1;
        button[3] = 1'b1;
        run(7);
        chk("conf_early", cf_n, 0);
        tick();
        chk("conf_cf", {31'd0, conflict}, 1);
        chk("conf_vv", {31'd0, vote_valid}, 0);
        chk("conf_ch", {30'd0, vote_ch}, 0);
        chk("conf_busy", {31'd0, busy}, 1);
        run(6);
        chk("conf_once", cf_n, 0);
        chk("conf_novote", vv_n, 0);
        button = 4'b0000;
        run(5);

        // second qualification inside cooldown is dropped
        button[0] = 1'b1;
        tick();
        button[1] = 1'b1;
        run(6);
        tick();
        chk("cool_vv", {31'd0, vote_valid}, 1);
        chk("cool_ch", {30'd0, vote_ch}, 0);
        run(10);
        chk("cool_drop_vv", vv_n, 0);
        chk("cool_drop_cf", cf_n, 0);
        button = 4'b0000;
        run(5);
        button[1] = 1'b1;
        wait_vote(20, at);
        chk("cool_re_at", at, 8);
        chk("cool_re_ch", {30'd0, vote_ch}, 1);
        button = 4'b0000;
        run(5);

        // reset while a vote is being reported
        button[2] = 1'b1;
        wait_vote(20, at);
        chk("rst_v_at", at, 8);
        reset = 1'b0;
        #1;
        chk("rst_v_vv", {31'd0, vote_valid}, 0);
        chk("rst_v_busy", {31'd0, busy}, 0);
        tick();
        reset = 1'b1;
        wait_vote(20, at);
        chk("rst_v_requal", at, 8);
        button = 4'b0000;
        run(5);

        // reset mid-count, button held through it
        button[2] = 1'b1;
        run(4);
        reset = 1'b0;
        #1;
        chk("rst_c_vv", {31'd0, vote_valid}, 0);
        chk("rst_c_ch", {30'd0, vote_ch}, 0);
        run(3);
        chk("rst_c_hold", vv_n, 0);
        reset = 1'b1;
        wait_vote(20, at);
        chk("rst_c_at", at, 8);
        chk("rst_c_ch2", {30'd0, vote_ch}, 2);
        button = 4'b0000;
        run(5);

        // back-to-back presses on channel 3
        button[3] = 1'b1;
        wait_vote(20, at);
        chk("b2b_at1", at, 8);
        chk("b2b_ch1", {30'd0, vote_ch}, 3);
        button[3] = 1'b0;
        tick();
        button[3] = 1'b1;
        wait_vote(20, at);
        chk("b2b_at2", at, 8);
        chk("b2b_ch2", {30'd0, vote_ch}, 3);
        chk("b2b_busy", {31'd0, busy}, 1);
        button = 4'b0000;
        run(5);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/vote_button_array.md
# vote_button_array

Multi-channel vote-button qualifier for the voting machine front end. Each of `NUM_CH` raw candidate buttons is synchronised, then held-time qualified. A single one-cycle vote pulse with the candidate index is emitted once per press. Simultaneous qualifications are rejected as a conflict, and a post-vote cooldown blocks rapid repeat voting. The block feeds the vote counters directly.

## Interface
- `NUM_CH`, 4: number of button channels, ≥1.
- `HOLD_CYCLES`, 100000000: consecutive high samples required to qualify a press (1 s at 100 MHz), ≥1.
- `COOLDOWN_CYCLES`, 50000000: cycles after a vote/conflict during which new qualifications are discarded; 0 disables.
- `CNT_W`, derived: `$clog2(HOLD_CYCLES+1)`.
- `CH_W`, derived: `max(1, $clog2(NUM_CH))`.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-low reset. Low clears all state immediately.
- `button` in NUM_CH: raw asynchronous button levels, active-high.
- `vote_valid` out 1: one-cycle pulse, one qualified vote.
- `vote_ch` out CH_W: index of the voted channel; valid only with `vote_valid`, 0 otherwise.
- `conflict` out 1: one-cycle pulse, ≥2 channels qualified in the same cycle.
- `busy` out 1: high while cooldown is running.

## Operation
- **Synchroniser:** 2-flop per channel, reset to 0. Only the second stage (`s2`) is used downstream.
- **Per-channel FSM:**
  - IDLE (cnt=0): `s2`=1 → COUNT, cnt=1.
  - COUNT: `s2`=0 → IDLE, cnt=0. `s2`=1 and cnt<HOLD_CYCLES → cnt+1. `s2`=1 and cnt==HOLD_CYCLES → raise `fire[i]` for one cycle, go to HELD.
  - HELD: `s2`=0 → IDLE. Otherwise stay. No repeat fire while held.
  - cnt saturates at HOLD_CYCLES and never wraps. One low sample anywhere in COUNT restarts qualification.
- **Arbiter**, evaluated in any cycle where some `fire[i]` is set:
  - cooldown>0: all fires discarded, no output. Channels still enter HELD.
  - Exactly one fire: `vote_valid`=1, `vote_ch`=i, cooldown loaded with COOLDOWN_CYCLES.
  - Two or more fires: `conflict`=1, `vote_valid`=0, cooldown loaded.
- **Cooldown counter:** decrements to 0. `busy` = (cooldown≠0). A fire arriving in the cycle cooldown reaches 0 is accepted.
- **Reset mid-operation:** all FSMs go to IDLE, counters and outputs clear. A button still held after reset deassertion is re-qualified from zero and can vote.

## Timing
- All outputs registered. Reset values: `vote_valid`=0, `vote_ch`=0, `conflict`=0, `busy`=0.
- If `button[i]` rises before edge e0 and stays high, `vote_valid` is high during the cycle after edge e0+HOLD_CYCLES+2 and low after the following edge.
- `busy` rises on the same edge as `vote_valid`/`conflict` and stays high for COOLDOWN_CYCLES cycles.
- Release-to-rearm: a new press is accepted from the cycle after `s2` is sampled low, i.e. 2 edges after the button falls.
- No handshake; the consumer must accept `vote_valid` every cycle.

## Structure
- Shared package `vote_pkg`:
  - channel FSM state enum (IDLE, COUNT, HELD);
  - `CLOG2`-style width helper;
  - default HOLD/COOLDOWN constants for a 100 MHz clock.
- Sub-module `vote_chan_qual`: synchroniser, counter and FSM for one channel, output `fire`. Generated NUM_CH times.
- Top level holds the arbiter (popcount + one-hot-to-index) and the cooldown counter.

## Test plan
Parameters: NUM_CH=4, HOLD_CYCLES=5, COOLDOWN_CYCLES=3.
- **Single press:** button[2] high from e0 for 20 cycles → one `vote_valid` pulse at edge e0+7, `vote_ch`=2, `busy` high 3 cycles, no further pulse while held.
- **Glitch:** button[1] high 4 cycles, low 1, high 10 → no vote until 7 edges after the second rise.
- **Conflict:** button[0] and button[3] rise on the same edge → `conflict` pulse at e0+7, no `vote_valid`, `busy` high.
- **Cooldown:**
  - button[1] qualifies 1 cycle after button[0]'s vote → discarded, no output.
  - Release both and press button[1] again → vote with `vote_ch`=1.
- **Reset:** assert `reset` low mid-COUNT on button[2] → outputs 0 immediately. Deassert with button still high → vote 7 edges after the first post-reset edge.
- **Back-to-back:** press, release and re-press button[3] as soon as cooldown allows → two separate `vote_valid` pulses, each `vote_ch`=3.
